// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, lane geometry and state encodings for the register-file write-port arbiter.
// Also provides the vector lane extraction helper.
package wb_port_arbiter_pkg;

    localparam int REG_WIDTH  = 16;
    localparam int VREG_WIDTH = 64;
    localparam int LANES      = VREG_WIDTH / REG_WIDTH;
    localparam int IDX_WIDTH  = 6;
    localparam int SQ_DEPTH   = 2;
    localparam int LANE_W     = $clog2(LANES);

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

    typedef enum logic {
        WB_IDLE   = 1'b0,
        WB_VBURST = 1'b1
    } wb_state_e;

    typedef enum logic {
        GR_SCALAR = 1'b0,
        GR_VECTOR = 1'b1
    } wb_grant_e;

    typedef struct packed {
        logic [IDX_WIDTH-1:0] idx;
        logic [REG_WIDTH-1:0] dat;
    } sq_entry_t;

    function automatic logic [REG_WIDTH-1:0] lane_slice(input logic [VREG_WIDTH-1:0] v,
                                                        input logic [LANE_W-1:0]     lane);
        return v[lane*REG_WIDTH +: REG_WIDTH];
    endfunction

endpackage

// File: rtl/wb_scalar_fifo.sv
// Small power-of-two FIFO buffering scalar writeback entries; head is visible combinationally.
// Latency: push to head visible after one edge; backpressure: push ignored when full, pop ignored when empty.
module wb_scalar_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 22
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // The extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin sharing of the 16-bit register-file write port between scalar FIFO and serialized vector lanes.
// Latency: accept to write visible two edges later; backpressure: readies depend on state only, I_LOCK=0 freezes all.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
(
    input  logic                  I_CLOCK,
    input  logic                  I_RESET_N,
    input  logic                  I_LOCK,
    input  logic                  I_SValid,
    output logic                  O_SReady,
    input  logic [IDX_WIDTH-1:0]  I_SRegIdx,
    input  logic [REG_WIDTH-1:0]  I_SData,
    input  logic                  I_VValid,
    output logic                  O_VReady,
    input  logic [IDX_WIDTH-1:0]  I_VRegIdx,
    input  logic [VREG_WIDTH-1:0] I_VData,
    output logic                  O_WrEnable,
    output logic                  O_WrVector,
    output logic [LANE_W-1:0]     O_WrLane,
    output logic [IDX_WIDTH-1:0]  O_WrRegIdx,
    output logic [REG_WIDTH-1:0]  O_WrData,
    output logic                  O_Busy
);

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_v_acc;
    sq_entry_t             w_push_dat;
    sq_entry_t             w_head;

    logic                  r_vhold_full;
    logic [IDX_WIDTH-1:0]  r_vhold_idx;
    logic [VREG_WIDTH-1:0] r_vhold_dat;

    wb_state_e             r_state;
    wb_state_e             w_state_nxt;
    wb_grant_e             r_last_grant;
    logic [LANE_W-1:0]     r_lane;

    logic                  w_grant_s;
    logic                  w_grant_v;
    logic                  w_burst_step;
    logic                  w_burst_last;

    logic                  w_nxt_en;
    logic                  w_nxt_vec;
    logic [LANE_W-1:0]     w_nxt_lane;
    logic [IDX_WIDTH-1:0]  w_nxt_idx;
    logic [REG_WIDTH-1:0]  w_nxt_dat;

    assign O_SReady   = I_RESET_N & I_LOCK & ~w_fifo_full;
    assign O_VReady   = I_RESET_N & I_LOCK & ~r_vhold_full;
    assign w_push     = I_SValid & O_SReady;
    assign w_v_acc    = I_VValid & O_VReady;
    assign w_push_dat = '{idx: I_SRegIdx, dat: I_SData};
    assign w_pop      = w_grant_s;

    wb_scalar_fifo #(
        .DEPTH (SQ_DEPTH),
        .WIDTH ($bits(sq_entry_t))
    ) u_sq (
        .i_clk      (I_CLOCK),
        .i_rst_n    (I_RESET_N),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) r_state <= WB_IDLE;
        else            r_state <= w_state_nxt;
    end

    // On a tie the path that did not win last time is granted.
    always_comb begin
        w_grant_s    = 1'b0;
        w_grant_v    = 1'b0;
        w_burst_step = I_LOCK && (r_state == WB_VBURST);
        w_burst_last = w_burst_step && (r_lane == LANE_LAST);
        if (I_LOCK && (r_state == WB_IDLE)) begin
            if (!w_fifo_empty && r_vhold_full) begin
                if (r_last_grant == GR_VECTOR) w_grant_s = 1'b1;
                else                           w_grant_v = 1'b1;
            end else if (!w_fifo_empty) begin
                w_grant_s = 1'b1;
            end else if (r_vhold_full) begin
                w_grant_v = 1'b1;
            end
        end
        w_state_nxt = r_state;
        case (r_state)
            WB_IDLE:   if (w_grant_v)    w_state_nxt = WB_VBURST;
            WB_VBURST: if (w_burst_last) w_state_nxt = WB_IDLE;
            default:                     w_state_nxt = WB_IDLE;
        endcase
    end

    always_comb begin
        w_nxt_en   = 1'b0;
        w_nxt_vec  = 1'b0;
        w_nxt_lane = '0;
        w_nxt_idx  = '0;
        w_nxt_dat  = '0;
        if (w_grant_s) begin
            w_nxt_en  = 1'b1;
            w_nxt_idx = w_head.idx;
            w_nxt_dat = w_head.dat;
        end else if (w_grant_v) begin
            w_nxt_en  = 1'b1;
            w_nxt_vec = 1'b1;
            w_nxt_idx = r_vhold_idx;
            w_nxt_dat = lane_slice(r_vhold_dat, '0);
        end else if (w_burst_step) begin
            w_nxt_en   = 1'b1;
            w_nxt_vec  = 1'b1;
            w_nxt_lane = r_lane;
            w_nxt_idx  = r_vhold_idx;
            w_nxt_dat  = lane_slice(r_vhold_dat, r_lane);
        end
    end

    // Lane counter holds while I_LOCK is low so a paused burst resumes at the same lane.
    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_lane       <= '0;
            r_last_grant <= GR_VECTOR;
            r_vhold_full <= 1'b0;
            r_vhold_idx  <= '0;
            r_vhold_dat  <= '0;
        end else begin
            if (w_grant_v)         r_lane <= LANE_W'(1);
            else if (w_burst_last) r_lane <= '0;
            else if (w_burst_step) r_lane <= r_lane + 1'b1;

            if (w_grant_s)      r_last_grant <= GR_SCALAR;
            else if (w_grant_v) r_last_grant <= GR_VECTOR;

            if (w_v_acc) begin
                r_vhold_full <= 1'b1;
                r_vhold_idx  <= I_VRegIdx;
                r_vhold_dat  <= I_VData;
            end else if (w_burst_last) begin
                r_vhold_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            O_WrEnable <= 1'b0;
            O_WrVector <= 1'b0;
            O_WrLane   <= '0;
            O_WrRegIdx <= '0;
            O_WrData   <= '0;
        end else begin
            O_WrEnable <= w_nxt_en;
            O_WrVector <= w_nxt_vec;
            O_WrLane   <= w_nxt_lane;
            O_WrRegIdx <= w_nxt_idx;
            O_WrData   <= w_nxt_dat;
        end
    end

    assign O_Busy = ~w_fifo_empty | r_vhold_full | (r_state != WB_IDLE) | O_WrEnable;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed table-driven bench for wb_port_arbiter with hand sequences for lock pause and mid-burst reset.
module tb_wb_port_arbiter;

    logic        I_CLOCK;
    logic        I_RESET_N;
    logic        I_LOCK;
    logic        I_SValid;
    logic        O_SReady;
    logic [5:0]  I_SRegIdx;
    logic [15:0] I_SData;
    logic        I_VValid;
    logic        O_VReady;
    logic [5:0]  I_VRegIdx;
    logic [63:0] I_VData;
    logic        O_WrEnable;
    logic        O_WrVector;
    logic [1:0]  O_WrLane;
    logic [5:0]  O_WrRegIdx;
    logic [15:0] O_WrData;
    logic        O_Busy;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [63:0] VC = 64'hA3A3_A2A2_A1A1_A0A0;
    localparam logic [63:0] VD = 64'h4D4D_3D3D_2D2D_1D1D;
    localparam logic [63:0] VB = 64'hDDDD_CCCC_BBBB_AAAA;
    localparam logic [63:0] VE = 64'h0E04_0E03_0E02_0E01;
    localparam logic [63:0] VF = 64'h0F04_0F03_0F02_0F01;

    wb_port_arbiter dut (
        .I_CLOCK    (I_CLOCK),
        .I_RESET_N  (I_RESET_N),
        .I_LOCK     (I_LOCK),
        .I_SValid   (I_SValid),
        .O_SReady   (O_SReady),
        .I_SRegIdx  (I_SRegIdx),
        .I_SData    (I_SData),
        .I_VValid   (I_VValid),
        .O_VReady   (O_VReady),
        .I_VRegIdx  (I_VRegIdx),
        .I_VData    (I_VData),
        .O_WrEnable (O_WrEnable),
        .O_WrVector (O_WrVector),
        .O_WrLane   (O_WrLane),
        .O_WrRegIdx (O_WrRegIdx),
        .O_WrData   (O_WrData),
        .O_Busy     (O_Busy)
    );

    initial I_CLOCK = 1'b0;
    always #5 I_CLOCK = ~I_CLOCK;

    typedef struct {
        logic        lock;
        logic        sv;
        logic [5:0]  sidx;
        logic [15:0] sdat;
        logic        vv;
        logic [5:0]  vidx;
        logic [63:0] vdat;
        logic [28:0] exp;
    } row_t;

    // Packed layout: {en, vec, lane[1:0], idx[5:0], dat[15:0], srdy, vrdy, busy}
    function automatic logic [28:0] pk(input int en, input int vec, input int lane, input int idx,
                                       input int dat, input int srdy, input int vrdy, input int busy);
        logic [28:0] p;
        p = {en[0], vec[0], lane[1:0], idx[5:0], dat[15:0], srdy[0], vrdy[0], busy[0]};
        return p;
    endfunction

    function automatic row_t r(input int lock, input int sv, input int sidx, input int sdat,
                               input int vv, input int vidx, input logic [63:0] vdat,
                               input int en, input int vec, input int lane, input int idx,
                               input int dat, input int srdy, input int vrdy, input int busy);
        row_t x;
        x.lock = lock[0];
        x.sv   = sv[0];
        x.sidx = sidx[5:0];
        x.sdat = sdat[15:0];
        x.vv   = vv[0];
        x.vidx = vidx[5:0];
        x.vdat = vdat;
        x.exp  = pk(en, vec, lane, idx, dat, srdy, vrdy, busy);
        return x;
    endfunction

    function automatic string fmt(input logic [28:0] p);
        return $sformatf("en=%0b vec=%0b lane=%0d idx=%0d dat=%h srdy=%0b vrdy=%0b busy=%0b",
                         p[28], p[27], p[26:25], p[24:19], p[18:3], p[2], p[1], p[0]);
    endfunction

    task automatic check(input string nm, input logic [28:0] exp);
        logic [28:0] act;
        act = {O_WrEnable, O_WrVector, O_WrLane, O_WrRegIdx, O_WrData, O_SReady, O_VReady, O_Busy};
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual {%s} expected {%s}", nm, fmt(act), fmt(exp));
    endtask

    task automatic apply(input row_t x, input string nm);
        I_LOCK    = x.lock;
        I_SValid  = x.sv;
        I_SRegIdx = x.sidx;
        I_SData   = x.sdat;
        I_VValid  = x.vv;
        I_VRegIdx = x.vidx;
        I_VData   = x.vdat;
        @(posedge I_CLOCK);
        #1;
        check(nm, x.exp);
    endtask

    row_t tbl[$];
    row_t seq[$];

    initial begin
        I_RESET_N = 1'b0;
        I_LOCK    = 1'b1;
        I_SValid  = 1'b0;
        I_SRegIdx = '0;
        I_SData   = '0;
        I_VValid  = 1'b0;
        I_VRegIdx = '0;
        I_VData   = '0;

        // Contention after reset: scalar wins the first tie, second scalar follows lane 3 with no bubble
        tbl.push_back(r(1,1,1,'h1111,1,2,VC,   0,0,0,0,0,       1,0,1));
        tbl.push_back(r(1,0,0,0,0,0,'0,        1,0,0,1,'h1111,  1,0,1));
        tbl.push_back(r(1,0,0,0,0,0,'0,        1,1,0,2,'hA0A0,  1,0,1));
        tbl.push_back(r(1,1,7,'h7777,0,0,'0,   1,1,1,2,'hA1A1,  1,0,1));
        tbl.push_back(r(1,0,0,0,0,0,'0,        1,1,2,2,'hA2A2,  1,0,1));
        tbl.push_back(r(1,0,0,0,0,0,'0,        1,1,3,2,'hA3A3,  1,1,1));
        tbl.push_back(r(1,0,0,0,0,0,'0,        1,0,0,7,'h7777,  1,1,1));
        tbl.push_back(r(1,0,0,0,0,0,'0,        0,0,0,0,0,       1,1,0));
        // FIFO full during burst: third scalar held off, order preserved
        tbl.push_back(r(1,0,0,0,1,9,VD,        0,0,0,0,0,       1,0,1));
        tbl.push_back(r(1,1,10,'h0A01,0,0,'0,  1,1,0,9,'h1D1D,  1,0,1));
        tbl.push_back(r(1,1,11,'h0B02,0,0,'0,  1,1,1,9,'h2D2D,  0,0,1));
        tbl.push_back(r(1,1,12,'h0C03,0,0,'0,  1,1,2,9,'h3D3D,  0,0,1));
        tbl.push_back(r(1,1,12,'h0C03,0,0,'0,  1,1,3,9,'h4D4D,  0,1,1));
        tbl.push_back(r(1,1,12,'h0C03,0,0,'0,  1,0,0,10,'h0A01, 1,1,1));
        tbl.push_back(r(1,1,12,'h0C03,0,0,'0,  1,0,0,11,'h0B02, 1,1,1));
        tbl.push_back(r(1,0,0,0,0,0,'0,        1,0,0,12,'h0C03, 1,1,1));
        tbl.push_back(r(1,0,0,0,0,0,'0,        0,0,0,0,0,       1,1,0));
        // Scalar only
        tbl.push_back(r(1,1,3,'h1234,0,0,'0,   0,0,0,0,0,       1,1,1));
        tbl.push_back(r(1,0,0,0,0,0,'0,        1,0,0,3,'h1234,  1,1,1));
        tbl.push_back(r(1,0,0,0,0,0,'0,        0,0,0,0,0,       1,1,0));
        // Vector only
        tbl.push_back(r(1,0,0,0,1,5,VB,        0,0,0,0,0,       1,0,1));
        tbl.push_back(r(1,0,0,0,0,0,'0,        1,1,0,5,'hAAAA,  1,0,1));
        tbl.push_back(r(1,0,0,0,0,0,'0,        1,1,1,5,'hBBBB,  1,0,1));
        tbl.push_back(r(1,0,0,0,0,0,'0,        1,1,2,5,'hCCCC,  1,0,1));
        tbl.push_back(r(1,0,0,0,0,0,'0,        1,1,3,5,'hDDDD,  1,1,1));
        tbl.push_back(r(1,0,0,0,0,0,'0,        0,0,0,0,0,       1,1,0));

        #12;
        check("reset_state", pk(0,0,0,0,0, 0,0,0));
        I_RESET_N = 1'b1;
        #1;
        check("reset_release_readies", pk(0,0,0,0,0, 1,1,0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

        // Lock dropped after lane 1 for three cycles while a scalar is offered
        seq.push_back(r(1,0,0,0,1,20,VE,       0,0,0,0,0,       1,0,1));
        seq.push_back(r(1,0,0,0,0,0,'0,        1,1,0,20,'h0E01, 1,0,1));
        seq.push_back(r(1,0,0,0,0,0,'0,        1,1,1,20,'h0E02, 1,0,1));
        seq.push_back(r(0,1,30,'h3E3E,0,0,'0,  0,0,0,0,0,       0,0,1));
        seq.push_back(r(0,1,30,'h3E3E,0,0,'0,  0,0,0,0,0,       0,0,1));
        seq.push_back(r(0,1,30,'h3E3E,0,0,'0,  0,0,0,0,0,       0,0,1));
        seq.push_back(r(1,0,0,0,0,0,'0,        1,1,2,20,'h0E03, 1,0,1));
        seq.push_back(r(1,0,0,0,0,0,'0,        1,1,3,20,'h0E04, 1,1,1));
        seq.push_back(r(1,0,0,0,0,0,'0,        0,0,0,0,0,       1,1,0));
        for (int i = 0; i < seq.size(); i++) apply(seq[i], $sformatf("lock[%0d]", i));

        // Reset pulsed after lane 2
        apply(r(1,0,0,0,1,21,VF,   0,0,0,0,0,       1,0,1), "rst_accept");
        apply(r(1,0,0,0,0,0,'0,    1,1,0,21,'h0F01, 1,0,1), "rst_lane0");
        apply(r(1,0,0,0,0,0,'0,    1,1,1,21,'h0F02, 1,0,1), "rst_lane1");
        apply(r(1,0,0,0,0,0,'0,    1,1,2,21,'h0F03, 1,0,1), "rst_lane2");
        I_RESET_N = 1'b0;
        #1;
        check("rst_async_clear", pk(0,0,0,0,0, 0,0,0));
        #2;
        I_RESET_N = 1'b1;
        #1;
        check("rst_released_idle", pk(0,0,0,0,0, 1,1,0));
        apply(r(1,1,22,'h5A5A,0,0,'0, 0,0,0,0,0,       1,1,1), "post_rst_push");
        apply(r(1,0,0,0,0,0,'0,       1,0,0,22,'h5A5A, 1,1,1), "post_rst_write");
        apply(r(1,0,0,0,0,0,'0,       0,0,0,0,0,       1,1,0), "post_rst_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
